// File: rtl/prio_enc_mux_pipe.sv
// Priority encoder built as a log2(N)-level 2:1 mux tree, registered behind a valid/ready handshake.
// Optional multi-hot detection on out_err is enabled by defining PRIO_ENC_ONEHOT_CHK_EN.
module prio_enc_mux_pipe #(
    parameter int N  = 8,
    parameter int W  = $clog2(N),
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          msb_first,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_code,
    output logic          out_any,
    output logic          out_err,
    output logic [CW-1:0] hit_cnt
);

    // Level 0 holds the raw request bits; level W, node 0 holds the final result.
    logic [N-1:0] any_t  [W+1];
    logic [W-1:0] code_t [W+1][N];
    logic [W-1:0] enc_code_s;
    logic         enc_any_s;
    logic         accept_s;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_code_q,  out_code_d;
    logic          out_any_q,   out_any_d;
    logic [CW-1:0] hit_cnt_q,   hit_cnt_d;

    // Mux-tree core: each node picks the preferred half if that half has any bit set.
    always_comb begin
        for (int l = 0; l <= W; l++) begin
            any_t[l] = '0;
            for (int j = 0; j < N; j++) begin
                code_t[l][j] = '0;
            end
        end
        any_t[0] = in_data;
        for (int l = 1; l <= W; l++) begin
            for (int j = 0; j < N / 2; j++) begin
                if (j < (N >> l)) begin
                    logic lo_any;
                    logic hi_any;
                    logic sel_hi;
                    lo_any = any_t[l-1][2*j];
                    hi_any = any_t[l-1][2*j+1];
                    // LSB-first still falls to the upper half when the lower half is empty.
                    sel_hi = msb_first ? hi_any : (!lo_any && hi_any);
                    any_t[l][j]  = lo_any || hi_any;
                    code_t[l][j] = sel_hi ? code_t[l-1][2*j+1] : code_t[l-1][2*j];
                    code_t[l][j][l-1] = sel_hi;
                end else begin
                    any_t[l][j]  = 1'b0;
                    code_t[l][j] = '0;
                end
            end
        end
        enc_code_s = code_t[W][0];
        enc_any_s  = any_t[W][0];
    end

    assign in_ready  = !out_valid_q || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_any   = out_any_q;
    assign hit_cnt   = hit_cnt_q;

    // Next-state for the output register and the saturating hit counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_any_d   = out_any_q;
        hit_cnt_d   = hit_cnt_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_code_d  = enc_code_s;
            out_any_d   = enc_any_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (accept_s && enc_any_s && (hit_cnt_q != {CW{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // Result register and hit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_any_q   <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_any_q   <= out_any_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

`ifdef PRIO_ENC_ONEHOT_CHK_EN
    logic out_err_q, out_err_d;

    function automatic logic multi_hot(input logic [N-1:0] v);
        return |(v & (v - {{(N-1){1'b0}}, 1'b1}));
    endfunction

    // Error flag loads with the result and otherwise holds.
    always_comb begin
        out_err_d = out_err_q;
        if (accept_s) begin
            out_err_d = multi_hot(in_data);
        end else begin
            out_err_d = out_err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err_q <= 1'b0;
        end else begin
            out_err_q <= out_err_d;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule
